// File: rtl/alu_flags_stage.sv
// rtl/alu_flags_stage.sv - NZCV derivation, flag register and EX/MEM result register
module alu_flags_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] result,
    input  logic             carry_out,
    input  logic             overflow,
    input  logic [2:0]       ctrl,
    input  logic             set_flags,
    input  logic             stall,
    input  logic             flush,
    output logic [WIDTH-1:0] result_q,
    output logic             valid_q,
    output logic [3:0]       flags_q,
    output logic [3:0]       flags_fwd,
    output logic             zero_now,
    output logic             cond_lt
);

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;

    logic       arith_op;
    logic       flag_op;
    logic       we;
    logic [3:0] flags_new;

    always_comb begin
        arith_op  = (ctrl == OP_ADD) || (ctrl == OP_SUB);
        flag_op   = arith_op || (ctrl == OP_AND) || (ctrl == OP_OR) || (ctrl == OP_XOR);
        zero_now  = (result == '0);
        // Logical ops clear C and V regardless of what the adder produced.
        flags_new = {result[WIDTH-1], zero_now, arith_op & carry_out, arith_op & overflow};
        // Reset deliberately not folded in here; it wins at the register edge instead.
        we        = valid_in & set_flags & ~stall & ~flush & flag_op;
        flags_fwd = we ? flags_new : flags_q;
        cond_lt   = flags_fwd[3] ^ flags_fwd[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (we) begin
            flags_q <= flags_new;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else if (stall) begin
            result_q <= result_q;
            valid_q  <= valid_q;
        end else if (flush) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result;
            valid_q  <= valid_in;
        end
    end

endmodule

// File: tb/tb_alu_flags_stage.sv
// tb/tb_alu_flags_stage.sv - directed vectors for alu_flags_stage
module tb_alu_flags_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [63:0] result;
    logic        carry_out;
    logic        overflow;
    logic [2:0]  ctrl;
    logic        set_flags;
    logic        stall;
    logic        flush;
    logic [63:0] result_q;
    logic        valid_q;
    logic [3:0]  flags_q;
    logic [3:0]  flags_fwd;
    logic        zero_now;
    logic        cond_lt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_flags_stage #(.WIDTH(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .ctrl      (ctrl),
        .set_flags (set_flags),
        .stall     (stall),
        .flush     (flush),
        .result_q  (result_q),
        .valid_q   (valid_q),
        .flags_q   (flags_q),
        .flags_fwd (flags_fwd),
        .zero_now  (zero_now),
        .cond_lt   (cond_lt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] r, input logic c, input logic o,
                         input logic [2:0] op, input logic sf);
        valid_in  = v;
        result    = r;
        carry_out = c;
        overflow  = o;
        ctrl      = op;
        set_flags = sf;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b1, 64'hDEAD_BEEF_0000_1234, 1'b1, 1'b0, 3'b010, 1'b1);
        #1;
        chk("reset_fwd_comb", flags_fwd, 4'b1010);
        chk("reset_zero_now", zero_now, 1'b0);
        tick();
        tick();
        chk("reset_result_q", result_q, 64'h0);
        chk("reset_valid_q", valid_q, 1'b0);
        chk("reset_flags_q", flags_q, 4'b0000);
        reset = 1'b0;

        drive(1'b1, 64'h0, 1'b1, 1'b0, 3'b011, 1'b1);
        #1;
        chk("subs_fwd", flags_fwd, 4'b0110);
        chk("subs_zero_now", zero_now, 1'b1);
        chk("subs_cond_lt", cond_lt, 1'b0);
        tick();
        chk("subs_flags_q", flags_q, 4'b0110);
        chk("subs_result_q", result_q, 64'h0);
        chk("subs_valid_q", valid_q, 1'b1);

        drive(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 3'b010, 1'b1);
        #1;
        chk("adds_fwd", flags_fwd, 4'b1001);
        chk("adds_cond_lt", cond_lt, 1'b0);
        chk("adds_zero_now", zero_now, 1'b0);
        tick();
        chk("adds_flags_q", flags_q, 4'b1001);
        chk("adds_result_q", result_q, 64'h8000_0000_0000_0000);

        drive(1'b1, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 3'b100, 1'b1);
        #1;
        chk("ands_fwd", flags_fwd, 4'b1000);
        chk("ands_cond_lt", cond_lt, 1'b1);
        tick();
        chk("ands_flags_q", flags_q, 4'b1000);

        drive(1'b1, 64'h0, 1'b1, 1'b1, 3'b000, 1'b1);
        #1;
        chk("pass_fwd", flags_fwd, 4'b1000);
        chk("pass_zero_now", zero_now, 1'b1);
        tick();
        chk("pass_flags_q", flags_q, 4'b1000);
        chk("pass_result_q", result_q, 64'h0);

        drive(1'b1, 64'h5, 1'b1, 1'b0, 3'b010, 1'b0);
        tick();
        chk("add_nosf_flags_q", flags_q, 4'b1000);
        chk("add_nosf_result_q", result_q, 64'h5);

        drive(1'b1, 64'h77, 1'b1, 1'b1, 3'b111, 1'b1);
        #1;
        chk("unused_fwd", flags_fwd, 4'b1000);
        tick();
        chk("unused_flags_q", flags_q, 4'b1000);
        chk("unused_result_q", result_q, 64'h77);
        chk("unused_valid_q", valid_q, 1'b1);

        drive(1'b0, 64'h0, 1'b1, 1'b0, 3'b011, 1'b1);
        #1;
        chk("novalid_fwd", flags_fwd, 4'b1000);
        tick();
        chk("novalid_flags_q", flags_q, 4'b1000);
        chk("novalid_valid_q", valid_q, 1'b0);

        drive(1'b1, 64'h77, 1'b0, 1'b0, 3'b000, 1'b0);
        tick();
        chk("reload_valid_q", valid_q, 1'b1);

        drive(1'b1, 64'h0, 1'b1, 1'b0, 3'b011, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_fwd", flags_fwd, 4'b1000);
            tick();
            chk("stall_result_q", result_q, 64'h77);
            chk("stall_valid_q", valid_q, 1'b1);
            chk("stall_flags_q", flags_q, 4'b1000);
        end
        stall = 1'b0;
        flush = 1'b1;
        #1;
        chk("flush_fwd", flags_fwd, 4'b1000);
        tick();
        chk("flush_valid_q", valid_q, 1'b0);
        chk("flush_result_q", result_q, 64'h0);
        chk("flush_flags_q", flags_q, 4'b1000);
        flush = 1'b0;

        stall = 1'b1;
        drive(1'b1, 64'h0, 1'b1, 1'b0, 3'b011, 1'b1);
        tick();
        chk("stall1_flags_q", flags_q, 4'b1000);
        stall = 1'b0;
        #1;
        chk("release_fwd", flags_fwd, 4'b0110);
        tick();
        chk("release_flags_q", flags_q, 4'b0110);
        chk("release_valid_q", valid_q, 1'b1);

        drive(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 3'b010, 1'b1);
        reset = 1'b1;
        #1;
        chk("midreset_fwd", flags_fwd, 4'b1001);
        tick();
        chk("midreset_flags_q", flags_q, 4'b0000);
        chk("midreset_valid_q", valid_q, 1'b0);
        chk("midreset_result_q", result_q, 64'h0);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
